serial_tx_sched: RTL

SERIAL_TX_SCHED -- requirements
Module: serial_tx_sched

---
 rtl/serial_tx_sched_pkg.sv | 42 ++++
 rtl/ser_shift_reg.sv | 34 +++
 rtl/serial_tx_sched.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_tx_sched_pkg.sv
// ============================================================================
// Module   : serial_tx_sched_pkg
// Brief    : FSM state type and round-robin grant search for serial_tx_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_tx_sched_pkg;

`ifdef SERIAL_TX_SCHED_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

    localparam int c_MAX_REQ = 8;

    // Returns the first pending requester after 'last' (wrapping), or -1 if none.
    function automatic int rr_next(input logic [c_MAX_REQ-1:0] req,
                                   input int last,
                                   input int num);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= c_MAX_REQ; k++) begin
            idx = (last + k) % num;
            if ((k <= num) && (pick < 0) && req[idx])
                pick = idx;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ser_shift_reg.sv
// ============================================================================
// Module   : ser_shift_reg
// Brief    : Loadable right-shift register with asynchronous clear; LSB out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n)
            r_data <= '0;
        else if (i_load)
            r_data <= i_din;
        else if (i_shift)
            r_data <= {1'b0, r_data[WIDTH-1:1]};
    end

    assign o_lsb = r_data[0];

endmodule

`default_nettype wire

// File: rtl/serial_tx_sched.sv
// ============================================================================
// Module   : serial_tx_sched
// Brief    : Round-robin scheduler serialising requester words LSB first.
//            Define SERIAL_TX_SCHED_PARITY_EN to append an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_sched
    import serial_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          shift_en,
    output logic                          sout,
    output logic                          sout_valid,
    output logic                          sout_first,
    output logic                          sout_last,
    output logic [GW-1:0]                 gnt_id,
    output logic                          busy
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [GW-1:0]         r_last;
`ifdef SERIAL_TX_SCHED_PARITY_EN
    logic                  r_parity;
`endif

    logic [c_MAX_REQ-1:0]  w_req_pad;
    int                    w_pick;
    logic                  w_hit;
    logic [GW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_final;
    logic                  w_open;
    logic                  w_xfer;
    logic                  w_sr_bit;

    always_comb begin
        w_req_pad                 = '0;
        w_req_pad[NUM_REQ-1:0]    = req_valid;
        w_pick                    = rr_next(w_req_pad, int'(r_last), NUM_REQ);
        w_hit                     = (w_pick >= 0);
        w_idx                     = GW'(w_pick);
        w_word                    = req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
`ifdef SERIAL_TX_SCHED_PARITY_EN
        w_final                   = (r_state == PARITY);
`else
        w_final                   = (r_state == SHIFT) && (r_cnt == CW'(DATA_WIDTH-1));
`endif
        // Accept only when idle or when the last bit is actually leaving.
        w_open                    = resetn && ((r_state == IDLE) || (w_final && shift_en));
        w_xfer                    = w_open && w_hit;
        req_ready                 = w_xfer ? (NUM_REQ'(1) << w_idx) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            gnt_id   <= '0;
            r_last   <= GW'(NUM_REQ-1);
`ifdef SERIAL_TX_SCHED_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state  <= SHIFT;
            r_cnt    <= '0;
            gnt_id   <= w_idx;
            r_last   <= w_idx;
`ifdef SERIAL_TX_SCHED_PARITY_EN
            r_parity <= ^w_word;
`endif
        end else begin
            case (r_state)
                IDLE: ;
                SHIFT: begin
                    if (shift_en) begin
                        if (r_cnt == CW'(DATA_WIDTH-1)) begin
                            r_cnt <= '0;
`ifdef SERIAL_TX_SCHED_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
`ifdef SERIAL_TX_SCHED_PARITY_EN
                PARITY: begin
                    if (shift_en)
                        r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    ser_shift_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk     (clk),
        .i_clr_n (resetn),
        .i_load  (w_xfer),
        .i_shift ((r_state == SHIFT) && shift_en),
        .i_din   (w_word),
        .o_lsb   (w_sr_bit)
    );

    assign busy       = (r_state != IDLE);
    assign sout_valid = busy;
    assign sout_first = (r_state == SHIFT) && (r_cnt == '0);
    assign sout_last  = w_final;
`ifdef SERIAL_TX_SCHED_PARITY_EN
    assign sout       = ((r_state == SHIFT) && w_sr_bit) || ((r_state == PARITY) && r_parity);
`else
    assign sout       = (r_state == SHIFT) && w_sr_bit;
`endif

endmodule

`default_nettype wire
